// File: rtl/lvg_engine.sv
// NxN output-stationary systolic matrix-multiply engine with optional ReLU.
// Optional LVG_ACCUM_EN: keeps per-element raw sums so a job can accumulate onto the previous one.

module lvg_pe #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum
);
    logic [DW-1:0] prod;
    assign prod = a * b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     sum <= '0;
        else if (clr) sum <= '0;
        else if (en)  sum <= sum + prod;
    end
endmodule

module lvg_engine #(
    parameter int N    = 4,
    parameter int DW   = 32,
    parameter int RELU = 1,
    parameter int CW   = $clog2(3*N)+1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef LVG_ACCUM_EN
    input  logic              acc,
`endif
    input  logic [N*N*DW-1:0] m_flat,
    input  logic [N*N*DW-1:0] n_flat,
    output logic              busy,
    output logic              done,
    output logic [N*N*DW-1:0] r_flat
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] FEED = 3'd2;
    localparam logic [2:0] ACT  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]                      state;
    logic [CW-1:0]                   cnt;
    logic [N-1:0][N-1:0][DW-1:0]     m_q, n_q, sum_arr, s_val, r_q;
    logic [N-1:0][DW-1:0]            a_edge, b_edge;
    logic [N-1:0][N-1:0][DW-1:0]     a_h, b_v;
    logic [N-1:0][N-2:0][DW-1:0]     a_r;
    logic [N-2:0][N-1:0][DW-1:0]     b_r;
    logic                            cap, clr, en;
`ifdef LVG_ACCUM_EN
    logic                            acc_q;
    logic [N-1:0][N-1:0][DW-1:0]     s_prev;
`endif

    // DONE also accepts start so a held start sustains one job per 3N+1 cycles
    assign cap  = start && (state == IDLE || state == DONE);
    assign clr  = (state == LOAD);
    assign en   = (state == FEED);
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            m_q   <= '0;
            n_q   <= '0;
`ifdef LVG_ACCUM_EN
            acc_q <= 1'b0;
`endif
        end else begin
            if (cap) begin
                m_q   <= m_flat;
                n_q   <= n_flat;
`ifdef LVG_ACCUM_EN
                acc_q <= acc;
`endif
            end
            case (state)
                IDLE, DONE: state <= cap ? LOAD : IDLE;
                LOAD: begin
                    cnt   <= '0;
                    state <= FEED;
                end
                FEED: begin
                    if (cnt == CW'(3*N-3)) state <= ACT;
                    else                   cnt   <= cnt + 1'b1;
                end
                ACT:     state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Skewed edge feed: row i / column j see element k at count i+k / j+k
    always_comb begin
        a_edge = '0;
        b_edge = '0;
        if (state == FEED) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (cnt == CW'(i+k)) begin
                        a_edge[i] = m_q[i][k];
                        b_edge[i] = n_q[k][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || clr) begin
            a_r <= '0;
            b_r <= '0;
        end else if (en) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N-1; j++)
                    a_r[i][j] <= a_h[i][j];
            for (int i = 0; i < N-1; i++)
                for (int j = 0; j < N; j++)
                    b_r[i][j] <= b_v[i][j];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_ae
                assign a_h[i][j] = a_edge[i];
            end else begin : g_ai
                assign a_h[i][j] = a_r[i][j-1];
            end
            if (i == 0) begin : g_be
                assign b_v[i][j] = b_edge[j];
            end else begin : g_bi
                assign b_v[i][j] = b_r[i-1][j];
            end
            lvg_pe #(.DW(DW)) u_pe (
                .clk (clk),
                .rst (rst),
                .clr (clr),
                .en  (en),
                .a   (a_h[i][j]),
                .b   (b_v[i][j]),
                .sum (sum_arr[i][j])
            );
        end
    end

    always_comb begin
        s_val = sum_arr;
`ifdef LVG_ACCUM_EN
        if (acc_q) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    s_val[i][j] = s_prev[i][j] + sum_arr[i][j];
        end
`endif
    end

    // Result and raw-sum history only move on the ACT edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q    <= '0;
`ifdef LVG_ACCUM_EN
            s_prev <= '0;
`endif
        end else if (state == ACT) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    r_q[i][j] <= (RELU != 0 && s_val[i][j][DW-1]) ? '0 : s_val[i][j];
`ifdef LVG_ACCUM_EN
            s_prev <= s_val;
`endif
        end
    end

    assign r_flat = r_q;
endmodule

// File: tb/tb_lvg_engine.sv
// Scoreboard bench for lvg_engine: three lockstep instances (DW32 ReLU, DW8 raw, DW32 raw).
module tb_lvg_engine;
    localparam int N = 4;

    typedef logic [N-1:0][N-1:0][31:0] mat32_t;
    typedef logic [N-1:0][N-1:0][7:0]  mat8_t;
    typedef struct {
        mat32_t ra;
        mat8_t  rb;
        mat32_t rc;
        int     cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   start = 1'b0;
`ifdef LVG_ACCUM_EN
    logic   acc = 1'b0;
`endif
    mat32_t m_a = '0, n_a = '0, r_a, r_c;
    mat8_t  m_b = '0, n_b = '0, r_b;
    logic   busy_a, done_a, busy_b, done_b, busy_c, done_c;

    mat32_t mm, nn, sp_model = '0;
    exp_t   q[$];
    exp_t   me;
    int     cyc = 0;
    int     n_chk = 0;
    int     n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lvg_engine #(.N(N), .DW(32), .RELU(1)) dut_a (
        .clk(clk), .rst(rst), .start(start),
`ifdef LVG_ACCUM_EN
        .acc(acc),
`endif
        .m_flat(m_a), .n_flat(n_a), .busy(busy_a), .done(done_a), .r_flat(r_a));

    lvg_engine #(.N(N), .DW(8), .RELU(0)) dut_b (
        .clk(clk), .rst(rst), .start(start),
`ifdef LVG_ACCUM_EN
        .acc(acc),
`endif
        .m_flat(m_b), .n_flat(n_b), .busy(busy_b), .done(done_b), .r_flat(r_b));

    lvg_engine #(.N(N), .DW(32), .RELU(0)) dut_c (
        .clk(clk), .rst(rst), .start(start),
`ifdef LVG_ACCUM_EN
        .acc(acc),
`endif
        .m_flat(m_a), .n_flat(n_a), .busy(busy_c), .done(done_c), .r_flat(r_c));

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Plain matrix product mod 2^32, optional accumulation, then per-instance views
    task automatic calc(output exp_t e, input logic a);
        logic [31:0] s;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                s = '0;
                for (int k = 0; k < N; k++) s = s + mm[r][k] * nn[k][c];
                if (a) s = s + sp_model[r][c];
                sp_model[r][c] = s;
                e.ra[r][c] = s[31] ? 32'd0 : s;
                e.rb[r][c] = s[7:0];
                e.rc[r][c] = s;
            end
        end
    endtask

    task automatic build(input int kind);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (kind)
                    0: begin mm[r][c] = (r == c) ? 32'd1 : 32'd0; nn[r][c] = 32'(r*4+c); end
                    1: begin mm[r][c] = 32'hFFFF_FFFF; nn[r][c] = 32'd1; end
                    2: begin mm[r][c] = 32'd16; nn[r][c] = 32'd16; end
                    3: begin mm[r][c] = 32'(r+c); nn[r][c] = 32'(c-r); end
                    4: begin mm[r][c] = (r == c) ? -32'sd3 : 32'(r); nn[r][c] = 32'(r*c+1); end
                    5: begin mm[r][c] = 32'(r*4+c); nn[r][c] = 32'(15-(r*4+c)); end
                    6: begin mm[r][c] = (r == c) ? 32'd1 : 32'd0; nn[r][c] = 32'd2; end
                    default: begin mm[r][c] = 32'hDEAD_BEEF; nn[r][c] = 32'h1234_5678; end
                endcase
            end
        end
    endtask

    task automatic issue(input logic a_acc, input logic push);
        exp_t e;
        if (push) calc(e, a_acc);
        e.cyc = cyc + 13;
        m_a = mm;
        n_a = nn;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                m_b[r][c] = mm[r][c][7:0];
                n_b[r][c] = nn[r][c][7:0];
            end
`ifdef LVG_ACCUM_EN
        acc = a_acc;
`endif
        start = 1'b1;
        if (push) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk(nm, q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst && done_a) begin
            if (q.size() == 0) chk("spurious_done", 1, 0);
            else begin
                me = q.pop_front();
                chk("r_relu32", r_a, me.ra);
                chk("r_raw8", r_b, me.rb);
                chk("r_raw32", r_c, me.rc);
                chk("done_cyc", cyc, me.cyc);
                chk("done_lockstep", {done_b, done_c}, 2'b11);
            end
        end
    end

    initial begin
        int bcnt;
        #1 rst = 1'b0;
        #2;
        chk("rst_busy", {busy_a, busy_b, busy_c}, 3'b000);
        chk("rst_done", {done_a, done_b, done_c}, 3'b000);
        chk("rst_r32", r_a, 0);
        chk("rst_r8", r_b, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        // identity times ramp, busy run length
        build(0);
        issue(1'b0, 1'b1);
        start = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_a) bcnt++;
            @(negedge clk);
        end
        chk("busy_cycles", bcnt, 13);
        drain("drain_t1");

        // negative sums: ReLU clamps, raw view wraps
        build(1);
        issue(1'b0, 1'b1);
        start = 1'b0;
        drain("drain_t2");

        // 4*256 wraps to zero in the 8-bit instance; stray start in FEED ignored
        build(2);
        issue(1'b0, 1'b1);
        start = 1'b0;
        repeat (4) @(negedge clk);
        build(7);
        m_a = mm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("drain_t3");

        // start held high across three back-to-back jobs
        build(3);
        issue(1'b0, 1'b1);
        m_a = ~m_a;
        repeat (12) @(negedge clk);
        build(4);
        issue(1'b0, 1'b1);
        repeat (12) @(negedge clk);
        build(5);
        issue(1'b0, 1'b1);
        start = 1'b0;
        drain("drain_t4");

        // async reset mid-FEED aborts the job
        build(4);
        issue(1'b0, 1'b0);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", {busy_a, busy_b, busy_c}, 3'b000);
        chk("abort_done", {done_a, done_b, done_c}, 3'b000);
        chk("abort_r32", r_c, 0);
        chk("abort_r8", r_b, 0);
        sp_model = '0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        build(3);
        issue(1'b0, 1'b1);
        start = 1'b0;
        drain("drain_t5");

`ifdef LVG_ACCUM_EN
        build(6);
        issue(1'b0, 1'b1);
        start = 1'b0;
        drain("drain_accA");
        issue(1'b1, 1'b1);
        start = 1'b0;
        drain("drain_accB");
        issue(1'b0, 1'b1);
        start = 1'b0;
        drain("drain_accC");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
